// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control path: FSM state encoding, ALU
// operation codes, condition codes, datapath select encodings, the per-state
// control word and the data-processing ALU decode helper.
package cpu_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned COND_W  = 4;
    localparam int unsigned FLAGS_W = 4;

    // Multicycle sequencer states; the encoding is visible on the State port.
    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Instruction class, Instr[27:26]
    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // Condition field, Instr[31:28]
    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;
    localparam logic [COND_W-1:0] COND_NV = 4'b1111;

    // Bit positions inside the NZCV register
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ImmSrc selects
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // Ungated control word produced by the FSM output decode
    typedef struct packed {
        logic       pc_fetch;
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
    } ctrl_t;

    // Data-processing decode result
    typedef struct packed {
        logic [1:0] alu_ctl;
        logic [1:0] flag_w;
    } alu_dec_t;

    // Decode {cmd, S} = Funct[4:0]; unsupported commands fall back to ADD
    // with flag writes suppressed.
    function automatic alu_dec_t alu_decode(input logic [4:0] cmd_s);
        alu_dec_t d;
        logic     supported;
        d.alu_ctl = ALU_ADD;
        d.flag_w  = 2'b00;
        supported = 1'b1;
        case (cmd_s[4:1])
            4'b0100: d.alu_ctl = ALU_ADD;
            4'b0010: d.alu_ctl = ALU_SUB;
            4'b0000: d.alu_ctl = ALU_AND;
            4'b1100: d.alu_ctl = ALU_ORR;
            default: supported = 1'b0;
        endcase
        if (supported) begin
            d.flag_w[1] = cmd_s[0];
            d.flag_w[0] = cmd_s[0] & ((d.alu_ctl == ALU_ADD) | (d.alu_ctl == ALU_SUB));
        end
        return d;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator, shared with the pipelined build.
// Ports:
//   cond_i    - condition field Instr[31:28]
//   flags_i   - registered NZCV flags
//   cond_ex_o - 1 when the instruction is allowed to commit
module cond_check
    import cpu_ctrl_pkg::*;
(
    input  logic [COND_W-1:0]  cond_i,
    input  logic [FLAGS_W-1:0] flags_i,
    output logic               cond_ex_o
);

    logic n, z, c, v, ge;

    assign n  = flags_i[FLAG_N];
    assign z  = flags_i[FLAG_Z];
    assign c  = flags_i[FLAG_C];
    assign v  = flags_i[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = ge;
            COND_LT: cond_ex_o = ~ge;
            COND_GT: cond_ex_o = ~z & ge;
            COND_LE: cond_ex_o = z | ~ge;
            COND_AL: cond_ex_o = 1'b1;
            COND_NV: cond_ex_o = 1'b0;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, drives the shared datapath selects, owns the
// NZCV register and gates every architectural write with the condition check.
// Ports:
//   clk, reset_n        - rising-edge clock, async active-low reset
//   Cond/Op/Funct/Rd    - instruction register fields
//   ALUFlags            - NZCV produced by the ALU this cycle
//   PCWrite/MemWrite/RegWrite/IRWrite - gated write enables
//   AdrSrc/RegSrc/ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/ALUControl - datapath selects
//   Flags, State        - current NZCV and FSM state for debug
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [COND_W-1:0]  Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic [FLAGS_W-1:0] ALUFlags,
    output logic               PCWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         RegSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         ALUControl,
    output logic [FLAGS_W-1:0] Flags,
    output logic [STATE_W-1:0] State
);

    state_t               state_q, state_d;
    logic [FLAGS_W-1:0]   flags_q, flags_d;
    ctrl_t                ctrl;
    alu_dec_t             alu_dec;
    logic [1:0]           alu_ctl;
    logic [1:0]           flag_w;
    logic                 cond_ex;
    logic                 pcs;
    logic                 in_execute;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:   state_d = MEMADR;
                    OP_DP:    state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:    state_d = BRANCH;
                    OP_UNDEF: state_d = UNKNOWN;
                    default:  state_d = UNKNOWN;
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            UNKNOWN:  state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Per-state control word, before condition gating
    always_comb begin
        ctrl = '0;
        case (state_q)
            FETCH: begin
                ctrl.pc_fetch   = 1'b1;
                ctrl.ir_write   = 1'b1;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            MEMADR: begin
                ctrl.alu_src_b  = SRCB_IMM;
            end
            MEMREAD: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
            end
            MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_w      = 1'b1;
            end
            EXECUTER: begin
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = 1'b1;
            end
            EXECUTEI: begin
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = 1'b1;
            end
            ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALURESULT;
                ctrl.branch     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // ALU operation; non-execute states always add
    assign alu_dec = alu_decode(Funct[4:0]);
    assign alu_ctl = ctrl.alu_op ? alu_dec.alu_ctl : ALU_ADD;
    assign flag_w  = ctrl.alu_op ? alu_dec.flag_w  : 2'b00;

    // Condition check against the pre-update flags
    cond_check u_cond_check (
        .cond_i    (Cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    // Flag update, only on the edge leaving an execute state
    assign in_execute = (state_q == EXECUTER) | (state_q == EXECUTEI);

    always_comb begin
        flags_d = flags_q;
        if (in_execute && cond_ex) begin
            if (flag_w[1]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (flag_w[0]) begin
                flags_d[FLAG_C] = ALUFlags[FLAG_C];
                flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // A writeback to R15 or a branch redirects the PC instead of the register file
    assign pcs = ((Rd == 4'hF) & ctrl.reg_w) | ctrl.branch;

    // All outputs forced low while reset is asserted
    assign PCWrite    = reset_n & (ctrl.pc_fetch | (pcs & cond_ex));
    assign RegWrite   = reset_n & ctrl.reg_w & cond_ex & ~pcs;
    assign MemWrite   = reset_n & ctrl.mem_w & cond_ex;
    assign IRWrite    = reset_n & ctrl.ir_write;
    assign AdrSrc     = reset_n & ctrl.adr_src;
    assign ALUSrcA    = reset_n & ctrl.alu_src_a;
    assign ALUSrcB    = reset_n ? ctrl.alu_src_b  : 2'b00;
    assign ResultSrc  = reset_n ? ctrl.result_src : 2'b00;
    assign ALUControl = reset_n ? alu_ctl         : 2'b00;

    // Register-read and extend selects follow the instruction class
    always_comb begin
        RegSrc = 2'b00;
        ImmSrc = IMM_DP;
        if (reset_n) begin
            RegSrc = {(Op == OP_MEM), (Op == OP_BR)};
            case (Op)
                OP_MEM:  ImmSrc = IMM_MEM;
                OP_BR:   ImmSrc = IMM_BR;
                default: ImmSrc = IMM_DP;
            endcase
        end
    end

    assign Flags = flags_q;
    assign State = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for the multicycle sequencer: directed instructions push
// hand-computed per-cycle expectations; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0] Flags, State;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Flags      (Flags),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // State numbers
    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3,
                           S_MWB = 4'd4, S_MW = 4'd5, S_XR = 4'd6, S_XI = 4'd7,
                           S_AWB = 4'd8, S_BR = 4'd9, S_UNK = 4'd10;
    // Enables {PCWrite, MemWrite, RegWrite, IRWrite}
    localparam logic [3:0] E_NONE = 4'b0000, E_FETCH = 4'b1001, E_REG = 4'b0010,
                           E_MEM = 4'b0100, E_PC = 4'b1000;
    // Selects {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
    localparam logic [7:0] X_FD   = 8'b0_1_10_10_00;
    localparam logic [7:0] X_MA   = 8'b0_0_01_00_00;
    localparam logic [7:0] X_MR   = 8'b1_0_00_00_00;
    localparam logic [7:0] X_MWB  = 8'b0_0_00_01_00;
    localparam logic [7:0] X_MW   = 8'b1_0_00_00_00;
    localparam logic [7:0] X_RADD = 8'b0_0_00_00_00;
    localparam logic [7:0] X_RSUB = 8'b0_0_00_00_01;
    localparam logic [7:0] X_RAND = 8'b0_0_00_00_10;
    localparam logic [7:0] X_IADD = 8'b0_0_01_00_00;
    localparam logic [7:0] X_AWB  = 8'b0_0_00_00_00;
    localparam logic [7:0] X_BR   = 8'b0_0_01_10_00;
    localparam logic [7:0] X_ZERO = 8'b0_0_00_00_00;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] en;
        logic [7:0] sel;
        logic [3:0] flg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v, input int cyc_no);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc_no, act, exp_v);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cycle++;
            check("state",   8'(State), 8'(e.st), n_cycle);
            check("enables", 8'({PCWrite, MemWrite, RegWrite, IRWrite}), 8'(e.en), n_cycle);
            check("selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, e.sel, n_cycle);
            check("flags",   8'(Flags), 8'(e.flg), n_cycle);
        end
    end

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
        Cond  = c;
        Op    = o;
        Funct = f;
        Rd    = r;
    endtask

    // Push this cycle's expectation, then advance to just after the next edge
    task automatic cyc(input logic [3:0] st, input logic [3:0] en, input logic [7:0] sel,
                       input logic [3:0] flg, input logic [3:0] af);
        exp_t e;
        ALUFlags = af;
        e.st  = st;
        e.en  = en;
        e.sel = sel;
        e.flg = flg;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fd(input logic [3:0] flg);
        cyc(S_F, E_FETCH, X_FD, flg, 4'h0);
        cyc(S_D, E_NONE,  X_FD, flg, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   wait_cnt;
        reset_n  = 1'b0;
        ALUFlags = 4'h0;
        set_instr(4'hE, 2'b00, 6'b000000, 4'h0);
        @(posedge clk);
        #1;
        // Reset: everything low, state FETCH
        cyc(S_F, E_NONE, X_ZERO, 4'h0, 4'h0);
        cyc(S_F, E_NONE, X_ZERO, 4'h0, 4'h0);
        reset_n = 1'b1;

        // ADDS R1,R2,#5 with ALUFlags 0110
        set_instr(4'hE, 2'b00, 6'b101001, 4'h1);
        fd(4'h0);
        cyc(S_XI,  E_NONE, X_IADD, 4'h0, 4'b0110);
        cyc(S_AWB, E_REG,  X_AWB,  4'h6, 4'h0);

        // LDR R3
        set_instr(4'hE, 2'b01, 6'b011001, 4'h3);
        fd(4'h6);
        cyc(S_MA,  E_NONE, X_MA,  4'h6, 4'h0);
        cyc(S_MR,  E_NONE, X_MR,  4'h6, 4'h0);
        cyc(S_MWB, E_REG,  X_MWB, 4'h6, 4'h0);

        // STR R3
        set_instr(4'hE, 2'b01, 6'b011000, 4'h3);
        fd(4'h6);
        cyc(S_MA, E_NONE, X_MA, 4'h6, 4'h0);
        cyc(S_MW, E_MEM,  X_MW, 4'h6, 4'h0);

        // BEQ with Z=1: taken
        set_instr(4'h0, 2'b10, 6'b100000, 4'h0);
        fd(4'h6);
        cyc(S_BR, E_PC, X_BR, 4'h6, 4'h0);

        // SUBS R4 with ALUFlags 0010: Flags become 0010
        set_instr(4'hE, 2'b00, 6'b000101, 4'h4);
        fd(4'h6);
        cyc(S_XR,  E_NONE, X_RSUB, 4'h6, 4'b0010);
        cyc(S_AWB, E_REG,  X_AWB,  4'h2, 4'h0);

        // BEQ with Z=0: not taken, back to FETCH
        set_instr(4'h0, 2'b10, 6'b100000, 4'h0);
        fd(4'h2);
        cyc(S_BR, E_NONE, X_BR, 4'h2, 4'h0);

        // SUBNE R15 with Z=0: PC written, not the register file
        set_instr(4'h1, 2'b00, 6'b000100, 4'hF);
        fd(4'h2);
        cyc(S_XR,  E_NONE, X_RSUB, 4'h2, 4'hF);
        cyc(S_AWB, E_PC,   X_AWB,  4'h2, 4'h0);

        // ANDS R5 with ALUFlags 0100: NZ loaded, CV kept -> 0110
        set_instr(4'hE, 2'b00, 6'b000001, 4'h5);
        fd(4'h2);
        cyc(S_XR,  E_NONE, X_RAND, 4'h2, 4'b0100);
        cyc(S_AWB, E_REG,  X_AWB,  4'h6, 4'h0);

        // SUBSNE R15 with Z=1: no writes, flags unchanged
        set_instr(4'h1, 2'b00, 6'b000101, 4'hF);
        fd(4'h6);
        cyc(S_XR,  E_NONE, X_RSUB, 4'h6, 4'b1001);
        cyc(S_AWB, E_NONE, X_AWB,  4'h6, 4'h0);

        // Op=11: UNKNOWN with nothing asserted
        set_instr(4'hE, 2'b11, 6'b000000, 4'h0);
        fd(4'h6);
        cyc(S_UNK, E_NONE, X_ZERO, 4'h6, 4'hF);

        // Unsupported Funct[4:1]=0101 with S=1: ADD, flags unchanged
        set_instr(4'hE, 2'b00, 6'b001011, 4'h2);
        fd(4'h6);
        cyc(S_XR,  E_NONE, X_RADD, 4'h6, 4'b1011);
        cyc(S_AWB, E_REG,  X_AWB,  4'h6, 4'h0);

        // LDR interrupted by reset in MEMREAD
        set_instr(4'hE, 2'b01, 6'b011001, 4'h7);
        fd(4'h6);
        cyc(S_MA, E_NONE, X_MA, 4'h6, 4'h0);
        e.st = S_MR; e.en = E_NONE; e.sel = X_MR; e.flg = 4'h6;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        cyc(S_F, E_NONE, X_ZERO, 4'h0, 4'h0);
        cyc(S_F, E_NONE, X_ZERO, 4'h0, 4'h0);
        reset_n = 1'b1;

        // First cycle after release is a clean FETCH, then a plain ADD R6
        set_instr(4'hE, 2'b00, 6'b001000, 4'h6);
        fd(4'h0);
        cyc(S_XR,  E_NONE,  X_RADD, 4'h0, 4'hF);
        cyc(S_AWB, E_REG,   X_AWB,  4'h0, 4'h0);
        cyc(S_F,   E_FETCH, X_FD,   4'h0, 4'h0);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
